// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM arbiter: agent encodings, default sizes and helpers.
// The display read path uses the same agent encodings.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    AG_DISP = 2'd0,
    AG_CPU  = 2'd1,
    AG_DRAW = 2'd2,
    AG_NONE = 2'd3
  } agent_t;

  localparam int ADDRW_DEFAULT      = 16;
  localparam int DATAW_DEFAULT      = 32;
  localparam int STARVE_MAX_DEFAULT = 15;
  localparam int TAG_STAGES         = 2;

  // Starve counter width: enough for STARVE_MAX, never narrower than 4 bits.
  function automatic int starve_width(input int smax);
    return ($clog2(smax + 1) < 4) ? 4 : $clog2(smax + 1);
  endfunction

endpackage

// File: rtl/vram_arb_if.sv
// Requester and VRAM-side signal bundle of the arbiter. The arbiter uses the slave
// modport; the system (requesters plus VRAM macro) uses the master modport.
interface vram_arb_if #(
  parameter int ADDRW = 16,
  parameter int DATAW = 32
);
  logic             disp_req;
  logic [ADDRW-1:0] disp_addr;
  logic             disp_ack;

  logic             draw_req;
  logic [ADDRW-1:0] draw_addr;
  logic [DATAW-1:0] draw_data;
  logic [DATAW-1:0] draw_mask;
  logic             draw_ack;

  logic             cpu_req;
  logic             cpu_we;
  logic [ADDRW-1:0] cpu_addr;
  logic [DATAW-1:0] cpu_wdata;
  logic             cpu_ack;

  logic [DATAW-1:0] rdata;
  logic             disp_rvalid;
  logic             cpu_rvalid;

  logic [ADDRW-1:0] mem_addr;
  logic             mem_we;
  logic [DATAW-1:0] mem_wmask;
  logic [DATAW-1:0] mem_wdata;
  logic [DATAW-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr,
    input  draw_req, draw_addr, draw_data, draw_mask,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata,
    output disp_ack, draw_ack, cpu_ack,
    output rdata, disp_rvalid, cpu_rvalid,
    output mem_addr, mem_we, mem_wmask, mem_wdata
  );

  modport master (
    output disp_req, disp_addr,
    output draw_req, draw_addr, draw_data, draw_mask,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata,
    input  disp_ack, draw_ack, cpu_ack,
    input  rdata, disp_rvalid, cpu_rvalid,
    input  mem_addr, mem_we, mem_wmask, mem_wdata
  );

endinterface

// File: rtl/vram_arb_rr2.sv
// Two-way round-robin between CPU and drawing engine; the agent not granted last wins a tie.
// `last` only moves when the top level actually grants the round-robin winner.
module vram_arb_rr2
  import vram_arb_pkg::*;
(
  input  logic   clk_sys,
  input  logic   rst_sys,
  input  logic   cpu_req,
  input  logic   draw_req,
  input  logic   take,
  output agent_t winner
);

  agent_t last_reg;
  agent_t last_next;

  always_ff @(posedge clk_sys) begin
    if (!rst_sys) begin
      last_reg <= AG_DRAW;
    end else begin
      last_reg <= last_next;
    end
  end

  always_comb begin
    winner = AG_NONE;
    if (cpu_req && draw_req) begin
      winner = (last_reg == AG_CPU) ? AG_DRAW : AG_CPU;
    end else if (cpu_req) begin
      winner = AG_CPU;
    end else if (draw_req) begin
      winner = AG_DRAW;
    end
  end

  always_comb begin
    last_next = last_reg;
    if (take && (winner != AG_NONE)) begin
      last_next = winner;
    end
  end

endmodule

// File: rtl/vram_arb.sv
// Shared-VRAM arbiter: display reads have priority, CPU and drawing engine share the rest
// round-robin, and a starvation counter bounds how long they can be locked out.
module vram_arb
  import vram_arb_pkg::*;
#(
  parameter int ADDRW      = ADDRW_DEFAULT,
  parameter int DATAW      = DATAW_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input logic       clk_sys,
  input logic       rst_sys,
  vram_arb_if.slave bus
);

  localparam int SW = starve_width(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  agent_t           rr_winner;
  agent_t           grant;
  agent_t           rd_tag;
  logic             rr_any;
  logic             starve_hit;
  logic             rr_take;
  logic [SW-1:0]    starve_reg, starve_next;
  logic [ADDRW-1:0] mem_addr_reg, mem_addr_next;
  logic             mem_we_reg, mem_we_next;
  logic [DATAW-1:0] mem_wmask_reg, mem_wmask_next;
  logic [DATAW-1:0] mem_wdata_reg, mem_wdata_next;
  agent_t           tag_reg  [TAG_STAGES];
  agent_t           tag_next [TAG_STAGES];

  vram_arb_rr2 u_rr (
    .clk_sys  (clk_sys),
    .rst_sys  (rst_sys),
    .cpu_req  (bus.cpu_req),
    .draw_req (bus.draw_req),
    .take     (rr_take),
    .winner   (rr_winner)
  );

  assign rr_any     = bus.cpu_req | bus.draw_req;
  assign starve_hit = rr_any && (starve_reg == STARVE_LIM);

  // Display wins unless a CPU/draw request has been refused long enough.
  always_comb begin
    grant = AG_NONE;
    if (rst_sys) begin
      if (bus.disp_req && !starve_hit) begin
        grant = AG_DISP;
      end else if (rr_any) begin
        grant = rr_winner;
      end
    end
  end

  assign rr_take      = (grant == AG_CPU) || (grant == AG_DRAW);
  assign bus.disp_ack = (grant == AG_DISP);
  assign bus.cpu_ack  = (grant == AG_CPU);
  assign bus.draw_ack = (grant == AG_DRAW);

  always_comb begin
    starve_next = '0;
    if (!rr_take && rr_any) begin
      starve_next = (starve_reg == STARVE_LIM) ? starve_reg : starve_reg + SW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_sys) begin
      starve_reg <= '0;
    end else begin
      starve_reg <= starve_next;
    end
  end

  // VRAM command for the accepted transaction; idle cycles keep the address and wdata.
  always_comb begin
    mem_addr_next  = mem_addr_reg;
    mem_we_next    = 1'b0;
    mem_wmask_next = '0;
    mem_wdata_next = mem_wdata_reg;
    rd_tag         = AG_NONE;
    case (grant)
      AG_DISP: begin
        mem_addr_next = bus.disp_addr;
        rd_tag        = AG_DISP;
      end
      AG_CPU: begin
        mem_addr_next = bus.cpu_addr;
        if (bus.cpu_we) begin
          mem_we_next    = 1'b1;
          mem_wmask_next = '1;
          mem_wdata_next = bus.cpu_wdata;
        end else begin
          rd_tag = AG_CPU;
        end
      end
      AG_DRAW: begin
        mem_addr_next  = bus.draw_addr;
        mem_we_next    = 1'b1;
        mem_wmask_next = bus.draw_mask;
        mem_wdata_next = bus.draw_data;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_sys) begin
      mem_addr_reg  <= '0;
      mem_we_reg    <= 1'b0;
      mem_wmask_reg <= '0;
      mem_wdata_reg <= '0;
    end else begin
      mem_addr_reg  <= mem_addr_next;
      mem_we_reg    <= mem_we_next;
      mem_wmask_reg <= mem_wmask_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_wmask = mem_wmask_reg;
  assign bus.mem_wdata = mem_wdata_reg;

  // Read-owner tags follow the VRAM latency so back-to-back reads return in order.
  genvar gi;
  generate
    for (gi = 0; gi < TAG_STAGES; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_next[gi] = rd_tag;
      end else begin : g_tail
        assign tag_next[gi] = tag_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < TAG_STAGES; i++) begin
      if (!rst_sys) begin
        tag_reg[i] <= AG_NONE;
      end else begin
        tag_reg[i] <= tag_next[i];
      end
    end
  end

  assign bus.rdata       = bus.mem_rdata;
  assign bus.disp_rvalid = (tag_reg[TAG_STAGES-1] == AG_DISP);
  assign bus.cpu_rvalid  = (tag_reg[TAG_STAGES-1] == AG_CPU);

endmodule
